// File: rtl/core_fetch_buf_pkg.sv
// Shared core defines for the fetch path: buffer depth, PC width, reset PC.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package core_fetch_buf_pkg;

  localparam int          FB_DEPTH = 4;
  localparam int          PC_W     = 32;
  localparam logic [31:0] PC_START = 32'h0000_0200;

  // Sequential next-PC; wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/core_fetch_buf_ram.sv
// Fetch buffer storage: DEPTH entries of {pc, instr}, separate pc / instr write ports.
// Latency: writes land on the rising edge, head read is asynchronous (same cycle).
// Backpressure: none; the controller guarantees the two ports never target the same field.
// Ports: clk; pc_we/pc_waddr/pc_wdata (allocate); instr_we/instr_waddr/instr_wdata (L1I ack);
//        raddr -> rd_pc/rd_instr (head).
module core_fetch_buf_ram
  import core_fetch_buf_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             pc_we,
  input  logic [PTR_W-1:0] pc_waddr,
  input  logic [PC_W-1:0]  pc_wdata,
  input  logic             instr_we,
  input  logic [PTR_W-1:0] instr_waddr,
  input  logic [31:0]      instr_wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [PC_W-1:0]  rd_pc,
  output logic [31:0]      rd_instr
);

  logic [PC_W-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  // Payload only; validity lives in the controller, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (pc_we)    pc_mem[pc_waddr]       <= pc_wdata;
    if (instr_we) instr_mem[instr_waddr] <= instr_wdata;
  end

  assign rd_pc    = pc_mem[raddr];
  assign rd_instr = instr_mem[raddr];

endmodule

// File: rtl/core_fetch_buf.sv
// Fetch buffer: records issued fetch PCs, pairs in-order L1I acks with them, feeds decode.
// Latency: ack in cycle N is visible to decode in N+1; 1 instr/cycle sustained.
// Backpressure: if_stall_out from registered state only (full, or drop counter saturated).
// Ports: clk, rst (sync, active-high); req_val_in/req_pc_in from fetch; l1i_ack_in/l1i_data_in
//        from L1I; kill_in redirect; dec_ready_in/dec_*_out to decode; if_stall_out to fetch.
module core_fetch_buf
  import core_fetch_buf_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_val_in,
  input  logic [PC_W-1:0] req_pc_in,
  input  logic            l1i_ack_in,
  input  logic [31:0]     l1i_data_in,
  input  logic            kill_in,
  input  logic            dec_ready_in,
  output logic            dec_val_out,
  output logic [31:0]     dec_instr_out,
  output logic [PC_W-1:0] dec_pc_out,
  output logic [PC_W-1:0] dec_pc_4_out,
  output logic            if_stall_out
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DROP_MAX = '1;

  logic [PTR_W-1:0] head, tail, dptr;
  logic [CNT_W-1:0] cnt, inflt, drop;
  logic [DEPTH-1:0] has_data;

  logic             alloc, ack_drop, ack_take, ack_old, deq;
  logic [CNT_W:0]   drop_sum;
  logic [CNT_W-1:0] drop_kill;
  logic [PC_W-1:0]  rd_pc;
  logic [31:0]      rd_instr;

  assign if_stall_out = (cnt == DEPTH_C) || (drop == DROP_MAX);
  assign alloc        = req_val_in && !if_stall_out;

  // Acks owed to squashed fetches are consumed before any live request sees data.
  assign ack_drop = l1i_ack_in && (drop != '0);
  assign ack_take = l1i_ack_in && (drop == '0) && (inflt != '0);
  assign ack_old  = ack_drop || ack_take;

  assign dec_val_out = (cnt != '0) && has_data[head] && !kill_in;
  assign deq         = dec_val_out && dec_ready_in;

  // On redirect every live in-flight request becomes a debt, minus an ack landing now.
  // Clamp rather than wrap: fetch is already stalled at DROP_MAX.
  assign drop_sum  = {1'b0, drop} + {1'b0, inflt} - (CNT_W + 1)'(ack_old);
  assign drop_kill = (drop_sum > {1'b0, DROP_MAX}) ? DROP_MAX : drop_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      dptr     <= '0;
      cnt      <= '0;
      inflt    <= '0;
      drop     <= '0;
      has_data <= '0;
    end else if (kill_in) begin
      head     <= '0;
      dptr     <= '0;
      has_data <= '0;
      drop     <= drop_kill;
      // A request in the redirect cycle is the first fetch on the new path: entry 0.
      tail     <= alloc ? PTR_W'(1) : '0;
      cnt      <= alloc ? CNT_W'(1) : '0;
      inflt    <= alloc ? CNT_W'(1) : '0;
    end else begin
      if (alloc) begin
        tail           <= tail + PTR_W'(1);
        has_data[tail] <= 1'b0;
      end
      if (ack_take) begin
        dptr           <= dptr + PTR_W'(1);
        has_data[dptr] <= 1'b1;
      end
      if (deq)      head <= head + PTR_W'(1);
      if (ack_drop) drop <= drop - CNT_W'(1);
      cnt   <= cnt + CNT_W'(alloc) - CNT_W'(deq);
      inflt <= inflt + CNT_W'(alloc) - CNT_W'(ack_take);
    end
  end

  core_fetch_buf_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk         (clk),
    .pc_we       (alloc),
    .pc_waddr    (kill_in ? '0 : tail),
    .pc_wdata    (req_pc_in),
    .instr_we    (ack_take && !kill_in),
    .instr_waddr (dptr),
    .instr_wdata (l1i_data_in),
    .raddr       (head),
    .rd_pc       (rd_pc),
    .rd_instr    (rd_instr)
  );

  assign dec_instr_out = dec_val_out ? rd_instr        : '0;
  assign dec_pc_out    = dec_val_out ? rd_pc           : '0;
  assign dec_pc_4_out  = dec_val_out ? pc_plus4(rd_pc) : '0;

endmodule

// File: tb/tb_core_fetch_buf.sv
// Directed bench for core_fetch_buf: hand-computed expectations per cycle.
// Inputs change 1 ns after the rising edge, outputs are sampled 1 ns later.
// Backpressure exercised via dec_ready_in low and buffer-full stall.
module tb_core_fetch_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_val_in = 1'b0;
  logic [31:0] req_pc_in = '0;
  logic        l1i_ack_in = 1'b0;
  logic [31:0] l1i_data_in = '0;
  logic        kill_in = 1'b0;
  logic        dec_ready_in = 1'b0;
  logic        dec_val_out;
  logic [31:0] dec_instr_out;
  logic [31:0] dec_pc_out;
  logic [31:0] dec_pc_4_out;
  logic        if_stall_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  core_fetch_buf dut (
    .clk           (clk),
    .rst           (rst),
    .req_val_in    (req_val_in),
    .req_pc_in     (req_pc_in),
    .l1i_ack_in    (l1i_ack_in),
    .l1i_data_in   (l1i_data_in),
    .kill_in       (kill_in),
    .dec_ready_in  (dec_ready_in),
    .dec_val_out   (dec_val_out),
    .dec_instr_out (dec_instr_out),
    .dec_pc_out    (dec_pc_out),
    .dec_pc_4_out  (dec_pc_4_out),
    .if_stall_out  (if_stall_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle and land 1 ns after the edge, ready to drive.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [31:0] pc,
                       input logic av, input logic [31:0] d, input logic k);
    req_val_in  = rv;
    req_pc_in   = pc;
    l1i_ack_in  = av;
    l1i_data_in = d;
    kill_in     = k;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, "_val"},  {31'd0, dec_val_out}, 32'd1);
    chk({tag, "_pc"},   dec_pc_out,           pc);
    chk({tag, "_ins"},  dec_instr_out,        ins);
    chk({tag, "_pc4"},  dec_pc_4_out,         pc + 32'd4);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_val"}, {31'd0, dec_val_out}, 32'd0);
    chk({tag, "_pc"},  dec_pc_out,           32'd0);
    chk({tag, "_ins"}, dec_instr_out,        32'd0);
    chk({tag, "_pc4"}, dec_pc_4_out,         32'd0);
  endtask

  initial begin
    // ---------------- reset ----------------
    tick(); tick();
    rst = 1'b0;
    #1;
    chk_empty("rst");
    chk("rst_stall", {31'd0, if_stall_out}, 32'd0);

    // ---------------- basic pair, ready high ----------------
    dec_ready_in = 1'b1;
    drive(1'b1, 32'h200, 1'b0, '0, 1'b0); tick();
    drive(1'b1, 32'h204, 1'b0, '0, 1'b0); tick();
    drive(1'b0, '0, 1'b1, 32'hAAAA_0001, 1'b0);
    chk("b_nodata", {31'd0, dec_val_out}, 32'd0);
    tick();
    drive(1'b0, '0, 1'b1, 32'hBBBB_0002, 1'b0);
    chk_head("b0", 32'h200, 32'hAAAA_0001);
    tick();
    idle();
    chk_head("b1", 32'h204, 32'hBBBB_0002);
    tick();
    chk("b_done", {31'd0, dec_val_out}, 32'd0);

    // ---------------- fill to stall, then drain ----------------
    dec_ready_in = 1'b0;
    drive(1'b1, 32'h300, 1'b0, '0, 1'b0);           tick();
    drive(1'b1, 32'h304, 1'b1, 32'h1111_0000, 1'b0); tick();
    drive(1'b1, 32'h308, 1'b1, 32'h1111_0001, 1'b0); tick();
    drive(1'b1, 32'h30C, 1'b1, 32'h1111_0002, 1'b0);
    chk("f_stall3", {31'd0, if_stall_out}, 32'd0);
    tick();
    drive(1'b0, '0, 1'b1, 32'h1111_0003, 1'b0);
    chk("f_stall4", {31'd0, if_stall_out}, 32'd1);
    chk_head("f_hold", 32'h300, 32'h1111_0000);
    tick();
    idle();
    dec_ready_in = 1'b1;
    #1;
    chk("f_stall_rdy", {31'd0, if_stall_out}, 32'd1);
    chk_head("f0", 32'h300, 32'h1111_0000);
    tick();
    chk("f_unstall", {31'd0, if_stall_out}, 32'd0);
    chk_head("f1", 32'h304, 32'h1111_0001);
    tick();
    chk_head("f2", 32'h308, 32'h1111_0002);
    tick();
    chk_head("f3", 32'h30C, 32'h1111_0003);
    tick();
    chk("f_done", {31'd0, dec_val_out}, 32'd0);

    // ---------------- kill with 3 in flight + redirect req ----------------
    drive(1'b1, 32'h500, 1'b0, '0, 1'b0); tick();
    drive(1'b1, 32'h504, 1'b0, '0, 1'b0); tick();
    drive(1'b1, 32'h508, 1'b0, '0, 1'b0); tick();
    drive(1'b1, 32'h400, 1'b0, '0, 1'b1);
    chk("k_killcyc", {31'd0, dec_val_out}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 32'hDEAD_0000 + i, 1'b0);
      tick();
      idle();
      chk($sformatf("k_drop%0d", i), {31'd0, dec_val_out}, 32'd0);
    end
    drive(1'b0, '0, 1'b1, 32'hD00D_0400, 1'b0); tick();
    idle();
    chk_head("k_new", 32'h400, 32'hD00D_0400);
    tick();
    chk("k_done", {31'd0, dec_val_out}, 32'd0);

    // ---------------- kill coincident with ack, 2 in flight ----------------
    drive(1'b1, 32'h600, 1'b0, '0, 1'b0);           tick();
    drive(1'b1, 32'h604, 1'b0, '0, 1'b0);           tick();
    drive(1'b0, '0, 1'b1, 32'hDEAD_0600, 1'b1);     tick();
    drive(1'b0, '0, 1'b1, 32'hDEAD_0604, 1'b0);     tick();
    idle();
    chk("ka_drop", {31'd0, dec_val_out}, 32'd0);
    drive(1'b1, 32'h700, 1'b0, '0, 1'b0);           tick();
    drive(1'b0, '0, 1'b1, 32'hEEEE_0700, 1'b0);     tick();
    idle();
    chk_head("ka_new", 32'h700, 32'hEEEE_0700);
    tick();

    // ---------------- kill vs. valid head with ready ----------------
    drive(1'b1, 32'h800, 1'b0, '0, 1'b0);           tick();
    drive(1'b0, '0, 1'b1, 32'hF000_0800, 1'b0);     tick();
    idle();
    chk_head("kh_pre", 32'h800, 32'hF000_0800);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    chk_empty("kh_kill");
    tick();
    idle();
    chk("kh_after", {31'd0, dec_val_out}, 32'd0);
    drive(1'b1, 32'h900, 1'b0, '0, 1'b0);           tick();
    drive(1'b0, '0, 1'b1, 32'hF000_0900, 1'b0);     tick();
    idle();
    chk_head("kh_next", 32'h900, 32'hF000_0900);
    tick();

    // ---------------- PC wrap ----------------
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, '0, 1'b0);     tick();
    drive(1'b0, '0, 1'b1, 32'h1234_5678, 1'b0);     tick();
    idle();
    chk_head("wrap", 32'hFFFF_FFFC, 32'h1234_5678);
    chk("wrap_pc4", dec_pc_4_out, 32'h0000_0000);
    tick();

    // ---------------- 10 back-to-back fetches, pointer wrap ----------------
    for (int k = 0; k < 12; k++) begin
      drive(k < 10, 32'h1000 + 32'(4 * k),
            (k >= 1) && (k <= 10), 32'hC0DE_0000 + 32'(k - 1), 1'b0);
      chk($sformatf("bb_stall%0d", k), {31'd0, if_stall_out}, 32'd0);
      if (k >= 2)
        chk_head($sformatf("bb%0d", k - 2), 32'h1000 + 32'(4 * (k - 2)),
                 32'hC0DE_0000 + 32'(k - 2));
      tick();
    end
    idle();
    chk("bb_done", {31'd0, dec_val_out}, 32'd0);

    // ---------------- reset mid-operation ----------------
    drive(1'b1, 32'hA00, 1'b0, '0, 1'b0);           tick();
    drive(1'b1, 32'hA04, 1'b1, 32'h5555_0A00, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk_empty("mrst");
    chk("mrst_stall", {31'd0, if_stall_out}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_fetch_buf.md
# core_fetch_buf

Fetch buffer between the instruction-fetch stage / L1I cache and the decode stage. It records every PC the fetch stage issues to L1I, pairs each in-order L1I response with its PC, and presents instruction + PC + PC+4 to decode with a valid/ready handshake. It back-pressures fetch when full and discards responses belonging to fetches squashed by a redirect (`kill_in`).

## Interface
- `DEPTH`, 4 — entries (allocated requests, with or without data); power of 2, ≥2.
- `clk`  in  1  — core clock, all state on rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `req_val_in`  in  1  — fetch issued a request to L1I this cycle.
- `req_pc_in`  in  32  — PC of that request.
- `l1i_ack_in`  in  1  — L1I returns data for the oldest outstanding request (in-order).
- `l1i_data_in`  in  32  — instruction word.
- `kill_in`  in  1  — redirect: squash everything buffered or in flight.
- `dec_ready_in`  in  1  — decode accepts the head this cycle.
- `dec_val_out`  out  1  — head entry holds a valid instruction.
- `dec_instr_out`  out  32  — head instruction; 0 when `dec_val_out`=0.
- `dec_pc_out`  out  32  — head PC; 0 when `dec_val_out`=0.
- `dec_pc_4_out`  out  32  — `dec_pc_out`+4 (mod 2^32); 0 when `dec_val_out`=0.
- `if_stall_out`  out  1  — fetch must not issue; drives fetch enable low.

## Operation
- Circular queue: head/tail pointers, allocation count `cnt` (0..DEPTH), per-entry `pc`, `instr`, `has_data`.
- Data pointer `dptr`: oldest allocated entry without data. Outstanding `inflt` = allocated entries lacking data.
- Drop counter `drop` (width log2(DEPTH)+1): acks still owed to squashed requests.
- Allocate: `req_val_in` && !`if_stall_out` → write `pc` at tail, clear `has_data`, tail++.
- Ack: if `drop`>0 → discard, `drop`--; else if `inflt`>0 → write `instr` at `dptr`, set `has_data`, `dptr`++; else ignore (protocol error).
- Deliver: `dec_val_out` = `cnt`>0 && head `has_data` && !`kill_in`; on `dec_val_out` && `dec_ready_in` → head++, `cnt`--.
- Kill: head=tail=dptr=0, `cnt`=0; `drop` ← `drop` + `inflt` − (ack consumed by old in-flight this cycle ? 1 : 0). No dequeue this cycle.
- Kill with `req_val_in` same cycle: that request is the redirected fetch; allocated in entry 0 after flush (`cnt`=1).
- `if_stall_out` = (`cnt`==DEPTH) || (`drop`==max); based on registered state only — no combinational path from `dec_ready_in`.
- Simultaneous allocate + dequeue: `cnt` unchanged; pointer wrap modulo DEPTH.

## Timing
- Reset: all pointers, `cnt`, `drop`, `has_data` = 0; all outputs 0.
- Ack in cycle N → `dec_val_out` earliest in N+1 (storage registered; outputs combinational from head).
- Request in cycle N counts toward `if_stall_out` in N+1.
- Dequeue at edge N → next head visible in N+1; sustained throughput 1 instr/cycle.
- Reset asserted mid-operation overrides kill, ack, allocate; in-flight L1I responses after reset are not tracked (L1I is reset together).

## Structure
- `DEPTH` default and PC width come from the shared core defines package together with `PC_START`.
- One sub-module: `core_fetch_buf_ram` — DEPTH×64 storage (pc, instr), one write port for allocate, one for ack, async read at head.
- Pointer/counter/drop logic stays in `core_fetch_buf`.

## Test plan
- Reset, then req PCs 0x200,0x204 with acks 2 cycles later, `dec_ready_in`=1 → decode sees (0x200,instr A,0x204) then (0x204,B,0x208), one per cycle.
- `dec_ready_in`=0, issue 4 requests + 4 acks → `if_stall_out`=1 after 4th request; raise ready → drains in order, stall drops the cycle after first dequeue.
- 3 requests outstanding, no acks, `kill_in` with req PC 0x400 → next 3 acks discarded, 4th ack delivered with PC 0x400.
- Kill coincident with an ack, 2 outstanding → only 1 further ack dropped.
- Head valid, `kill_in`=1 and `dec_ready_in`=1 same cycle → `dec_val_out`=0, nothing consumed, queue empty after.
- PC 0xFFFFFFFC fetched → `dec_pc_4_out`=0x00000000; pointers wrap across 10 back-to-back fetches with no loss.
